// File: rtl/aes_inv_cipher_core_if.sv
// Block-transfer bundle for the AES inverse cipher core: request/response,
// round-key lookup and the external combinational InvSubBytes path.
interface aes_inv_cipher_core_if;
  logic         start;
  logic [127:0] din;
  logic [3:0]   key_idx;
  logic [127:0] rkey;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic [127:0] dout;
  logic         busy;
  logic         done;

  // master: the requester that also hosts the key store and the InvSubBytes table
  modport master (
    output start, din, rkey, sb_out,
    input  key_idx, sb_in, dout, busy, done
  );

  modport slave (
    input  start, din, rkey, sb_out,
    output key_idx, sb_in, dout, busy, done
  );
endinterface

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher: one round per clock, with round keys and
// InvSubBytes supplied combinationally from outside. NR is 10, 12 or 14.
module aes_inv_cipher_core #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_inv_cipher_core_if.slave  bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);
  localparam logic [3:0] NR_M1  = 4'(NR - 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  // Declaration values give the reset-state outputs before the first clock edge
  fsm_t         fsm_reg   = IDLE;
  logic [127:0] state_reg = '0;
  logic [3:0]   round_reg = '0;
  logic [127:0] dout_reg  = '0;
  logic         busy_reg  = 1'b0;
  logic         done_reg  = 1'b0;

  logic [3:0]   key_idx_sel;
  logic [127:0] shifted;
  logic [127:0] mix_in;
  logic [127:0] mixed;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows: byte (r,c) takes the byte from column (c - r) mod 4 of row r
  for (genvar gi = 0; gi < 16; gi++) begin : g_shift
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign shifted[127-8*gi -: 8] = state_reg[127-8*SRC -: 8];
  end

  assign mix_in = bus.sb_out ^ bus.rkey;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mixed[127-32*gi -: 32] = inv_mix_col(mix_in[127-32*gi -: 32]);
  end

  always_comb begin
    key_idx_sel = NR_IDX;
    case (fsm_reg)
      ROUND:   key_idx_sel = round_reg;
      FINAL:   key_idx_sel = 4'd0;
      default: key_idx_sel = NR_IDX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      round_reg <= '0;
      dout_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= bus.din ^ bus.rkey;
            round_reg <= NR_M1;
            busy_reg  <= 1'b1;
            fsm_reg   <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= mixed;
          round_reg <= round_reg - 4'd1;
          if (round_reg == 4'd1) fsm_reg <= FINAL;
        end
        FINAL: begin
          dout_reg <= mix_in;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
          fsm_reg  <= IDLE;
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign bus.key_idx = key_idx_sel;
  assign bus.sb_in   = shifted;
  assign bus.dout    = dout_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Directed FIPS-197 checks of the inverse cipher core; the bench hosts the
// round-key store and InvSubBytes table the core expects to find outside.
module tb_aes_inv_cipher_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_inv_cipher_core_if if10 ();
  aes_inv_cipher_core_if if14 ();

  aes_inv_cipher_core #(.NR(10)) dut10 (.clk(clk), .reset(reset), .bus(if10));
  aes_inv_cipher_core #(.NR(14)) dut14 (.clk(clk), .reset(reset), .bus(if14));

  logic [2047:0]      sbox_flat;
  logic [2047:0]      isbox_flat;
  logic [128*15-1:0]  rk10_flat;
  logic [128*15-1:0]  rk14_flat;
  logic [128*15-1:0]  keys_b, keys_c1, keys_c3;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s, input logic [2047:0] tbl);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = tbl[int'(s[8*i +: 8])*8 +: 8];
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox_flat[int'(w[8*i +: 8])*8 +: 8];
    return o;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, output logic [128*15-1:0] flat);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr   = nk + 6;
    rc   = 8'h01;
    flat = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) flat[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  assign if10.rkey   = rk10_flat[int'(if10.key_idx)*128 +: 128];
  assign if10.sb_out = inv_sub(if10.sb_in, isbox_flat);
  assign if14.rkey   = rk14_flat[int'(if14.key_idx)*128 +: 128];
  assign if14.sb_out = inv_sub(if14.sb_in, isbox_flat);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One NR=10 block: accept, scramble din afterwards, watch NR+3 cycles
  task automatic block10(input logic [127:0] ct, input bit poke, output int lat,
                         output int n_done, output logic [127:0] pt, output logic [43:0] trace);
    @(negedge clk);
    if10.din   = ct;
    if10.start = 1'b1;
    trace      = {40'd0, if10.key_idx};
    @(negedge clk);
    if10.start = 1'b0;
    if10.din   = {$urandom(), $urandom(), $urandom(), $urandom()};
    lat    = -1;
    n_done = 0;
    pt     = '0;
    for (int n = 0; n < 13; n++) begin
      if (n < 10) trace = {trace[39:0], if10.key_idx};
      if (if10.done) begin
        n_done++;
        if (lat < 0) begin
          lat = n;
          pt  = if10.dout;
        end
      end
      if10.start = poke && (n == 2 || n == 6);
      @(negedge clk);
    end
    if10.start = 1'b0;
  endtask

  initial begin
    int           lat, nd, n;
    logic [127:0] pt;
    logic [43:0]  trace;
    logic [7:0]   inv, s;

    reset      = 1'b1;
    if10.start = 1'b1;
    if10.din   = '0;
    if14.start = 1'b0;
    if14.din   = '0;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = affine(inv);
      sbox_flat[x*8 +: 8]       = s;
      isbox_flat[int'(s)*8 +: 8] = 8'(x);
    end
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, keys_b);
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, keys_c1);
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, keys_c3);
    rk10_flat = keys_b;
    rk14_flat = keys_c3;

    #1;
    check("powerup_dout", if10.dout, 128'h0);
    check("powerup_busy", 128'(if10.busy), 128'h0);
    check("powerup_done", 128'(if10.done), 128'h0);

    // start held high throughout reset must not launch a block
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    if10.start = 1'b0;
    check("reset_prio_busy", 128'(if10.busy), 128'h0);
    check("reset_key_idx", 128'(if10.key_idx), 128'd10);

    block10(CT_B, 1'b0, lat, nd, pt, trace);
    check("appB_latency", 128'(lat), 128'd10);
    check("appB_dout", pt, PT_B);
    check("appB_done_count", 128'(nd), 128'd1);
    check("hold_dout", if10.dout, PT_B);

    rk10_flat = keys_c1;
    block10(CT_C1, 1'b1, lat, nd, pt, trace);
    check("poke_latency", 128'(lat), 128'd10);
    check("poke_done_count", 128'(nd), 128'd1);
    check("poke_key_trace", 128'(trace), 128'(44'hA9876543210));
    check("poke_dout", pt, PT_C);

    // back-to-back: second start presented in the done cycle
    rk10_flat = keys_b;
    @(negedge clk);
    if10.din   = CT_B;
    if10.start = 1'b1;
    @(negedge clk);
    if10.start = 1'b0;
    n = 0;
    while (!if10.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_latency", 128'(n), 128'd10);
    check("b2b_first_dout", if10.dout, PT_B);
    check("b2b_busy_in_done", 128'(if10.busy), 128'h0);
    rk10_flat  = keys_c1;
    if10.din   = CT_C1;
    if10.start = 1'b1;
    @(negedge clk);
    if10.start = 1'b0;
    n = 1;
    while (!if10.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b_gap", 128'(n), 128'd11);
    check("b2b_second_dout", if10.dout, PT_C);

    // reset five cycles into a block
    rk10_flat = keys_b;
    @(negedge clk);
    if10.din   = CT_B;
    if10.start = 1'b1;
    @(negedge clk);
    if10.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midblock_busy_before", 128'(if10.busy), 128'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 128'(if10.busy), 128'h0);
    check("abort_dout", if10.dout, 128'h0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      if (if10.done) nd++;
      @(negedge clk);
    end
    check("abort_no_done", 128'(nd), 128'd0);

    block10(CT_B, 1'b0, lat, nd, pt, trace);
    check("after_abort_latency", 128'(lat), 128'd10);
    check("after_abort_dout", pt, PT_B);

    @(negedge clk);
    if14.din   = CT_C3;
    if14.start = 1'b1;
    @(negedge clk);
    if14.start = 1'b0;
    if14.din   = '0;
    n = 0;
    while (!if14.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("nr14_latency", 128'(n), 128'd14);
    check("nr14_dout", if14.dout, PT_C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
